// File: rtl/md_hazard_pkg.sv
// -----------------------------------------------------------------------------
// md_hazard_pkg
// Shared definitions for the mult/div hazard and writeback controller:
//   - md_state_e : controller FSM state (IDLE, BUSY, WB)
//   - REG_W      : architectural register index width
//   - CNT_W      : latency counter width (latencies 1..63)
//   - MUL_LAT_DEF / DIV_LAT_DEF : default unit latencies in cycles
// -----------------------------------------------------------------------------
package md_hazard_pkg;

    localparam int REG_W = 5;
    localparam int CNT_W = 6;

    localparam int MUL_LAT_DEF = 4;
    localparam int DIV_LAT_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        WB   = 2'd2
    } md_state_e;

endpackage

// File: rtl/reg_hit.sv
// -----------------------------------------------------------------------------
// reg_hit
// Register-index match against the pending mult/div destination.
// Register 0 is hardwired to zero, so it never produces a hit.
// Ports:
//   i_idx   : register index from decode (rs, rt or rd)
//   i_pend  : pending destination register
//   o_hit   : indices equal and nonzero (not yet qualified by FSM state)
// -----------------------------------------------------------------------------
module reg_hit
    import md_hazard_pkg::*;
(
    input  logic [REG_W-1:0] i_idx,
    input  logic [REG_W-1:0] i_pend,
    output logic             o_hit
);

    assign o_hit = (i_idx == i_pend) && (i_idx != '0);

endmodule

// File: rtl/md_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// md_hazard_ctrl
// Hazard and writeback controller for the multi-cycle multiply/divide unit.
// Tracks the single outstanding mult/div destination, counts its latency,
// stalls decode on RAW/WAW hits or unit conflicts, and requests the shared
// register-file write port when the result is due.
//
// Parameters:
//   MUL_LAT : multiply latency in cycles, legal 1..63
//   DIV_LAT : divide latency in cycles, legal 1..63
// Ports:
//   clock      : sole clock, rising edge
//   reset      : synchronous, active-high
//   dec_valid  : decode instruction valid
//   dec_is_md  : decode instruction is mult/div
//   dec_is_div : 1 = divide, 0 = multiply (qualifies dec_is_md)
//   dec_writes : decode instruction writes dec_rd
//   dec_rs     : source register A
//   dec_rt     : source register B
//   dec_rd     : destination register
//   flush      : kill the decode instruction this cycle
//   wb_ack     : write-port grant for the mult/div result
//   stall      : hold decode (combinational)
//   md_start   : registered one-cycle start pulse to the unit
//   md_is_div  : registered operation select, valid with md_start
//   busy       : controller not idle
//   wb_req     : write-port request, high throughout WB
//   wb_rd      : pending destination, valid while wb_req
//
// Handshake: the result is written back on the edge where wb_req and wb_ack
// are both high; wb_req holds with stable wb_rd until that edge, and wb_ack
// outside WB has no effect.
// -----------------------------------------------------------------------------
module md_hazard_ctrl
    import md_hazard_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             dec_valid,
    input  logic             dec_is_md,
    input  logic             dec_is_div,
    input  logic             dec_writes,
    input  logic [REG_W-1:0] dec_rs,
    input  logic [REG_W-1:0] dec_rt,
    input  logic [REG_W-1:0] dec_rd,
    input  logic             flush,
    input  logic             wb_ack,
    output logic             stall,
    output logic             md_start,
    output logic             md_is_div,
    output logic             busy,
    output logic             wb_req,
    output logic [REG_W-1:0] wb_rd
);

    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    md_state_e        r_state;
    md_state_e        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [REG_W-1:0] r_pend_rd;
    logic             r_md_start;
    logic             r_md_is_div;

    logic             w_not_idle;
    logic             w_hit_rs;
    logic             w_hit_rt;
    logic             w_hit_rd;
    logic             w_stall;
    logic             w_accept;

    // -------------------------------------------------------------------------
    // Hazard detection against the pending destination
    // -------------------------------------------------------------------------
    reg_hit u_hit_rs (.i_idx(dec_rs), .i_pend(r_pend_rd), .o_hit(w_hit_rs));
    reg_hit u_hit_rt (.i_idx(dec_rt), .i_pend(r_pend_rd), .o_hit(w_hit_rt));
    reg_hit u_hit_rd (.i_idx(dec_rd), .i_pend(r_pend_rd), .o_hit(w_hit_rd));

    assign w_not_idle = (r_state != IDLE);

    // Hits only matter while a result is outstanding; a second mult/div is a
    // structural conflict for the whole time the unit is owned. WB still
    // stalls even when wb_ack is high: there is no forwarding path.
    assign w_stall = dec_valid && !flush && w_not_idle &&
                     (w_hit_rs || w_hit_rt || (dec_writes && w_hit_rd) || dec_is_md);

    // Only reachable in IDLE, since any mult/div outside IDLE stalls.
    assign w_accept = dec_valid && dec_is_md && !flush && !w_stall;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_accept)        w_state_nxt = BUSY;
            // cnt starts at LAT, so BUSY lasts exactly LAT cycles.
            BUSY: if (r_cnt == CNT_ONE) w_state_nxt = WB;
            WB:   if (wb_ack)          w_state_nxt = IDLE;
            default:                   w_state_nxt = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        busy   = 1'b0;
        wb_req = 1'b0;
        wb_rd  = '0;
        case (r_state)
            BUSY: begin
                busy = 1'b1;
            end
            WB: begin
                busy   = 1'b1;
                wb_req = 1'b1;
                wb_rd  = r_pend_rd;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath registers: latency counter, pending rd, start pulse
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt       <= '0;
            r_pend_rd   <= '0;
            r_md_start  <= 1'b0;
            r_md_is_div <= 1'b0;
        end else begin
            r_md_start <= w_accept;
            if (w_accept) begin
                r_cnt       <= dec_is_div ? DIV_CNT : MUL_CNT;
                r_pend_rd   <= dec_rd;
                r_md_is_div <= dec_is_div;
            end else if (r_state == BUSY) begin
                r_cnt <= r_cnt - CNT_ONE;
            end else if ((r_state == WB) && wb_ack) begin
                // Clearing pend_rd makes the released register unable to hit.
                r_pend_rd <= '0;
            end
        end
    end

    assign stall     = w_stall;
    assign md_start  = r_md_start;
    assign md_is_div = r_md_is_div;

endmodule

// File: tb/tb_md_hazard_ctrl.sv
module tb_md_hazard_ctrl;

    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 32;

    logic       clock;
    logic       reset;
    logic       dec_valid;
    logic       dec_is_md;
    logic       dec_is_div;
    logic       dec_writes;
    logic [4:0] dec_rs;
    logic [4:0] dec_rt;
    logic [4:0] dec_rd;
    logic       flush;
    logic       wb_ack;
    logic       stall;
    logic       md_start;
    logic       md_is_div;
    logic       busy;
    logic       wb_req;
    logic [4:0] wb_rd;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: one outstanding result, described by when it was
    // issued and the cycle at which its writeback becomes due.
    int         cyc = 0;
    bit         m_pending = 0;
    logic [4:0] m_rd = '0;
    bit         m_is_div = 0;
    int         m_start_cyc = -1;
    int         m_ready_at = 0;

    md_hazard_ctrl #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .dec_valid  (dec_valid),
        .dec_is_md  (dec_is_md),
        .dec_is_div (dec_is_div),
        .dec_writes (dec_writes),
        .dec_rs     (dec_rs),
        .dec_rt     (dec_rt),
        .dec_rd     (dec_rd),
        .flush      (flush),
        .wb_ack     (wb_ack),
        .stall      (stall),
        .md_start   (md_start),
        .md_is_div  (md_is_div),
        .busy       (busy),
        .wb_req     (wb_req),
        .wb_rd      (wb_rd)
    );

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit hit(input logic [4:0] x);
        return m_pending && (x == m_rd) && (x != 5'd0);
    endfunction

    function automatic bit model_stall();
        return dec_valid && !flush &&
               (hit(dec_rs) || hit(dec_rt) || (dec_writes && hit(dec_rd)) ||
                (dec_is_md && m_pending));
    endfunction

    function automatic int lat_of(input bit is_div);
        return is_div ? DIV_LAT : MUL_LAT;
    endfunction

    // Model update for the edge that ends cycle 'cyc'.
    task automatic model_edge(input bit e_stall);
        if (reset) begin
            m_pending   = 0;
            m_rd        = '0;
            m_is_div    = 0;
            m_start_cyc = -1;
        end else if (m_pending && (cyc >= m_ready_at) && wb_ack) begin
            m_pending = 0;
            m_rd      = '0;
        end else if (dec_valid && dec_is_md && !flush && !e_stall) begin
            m_pending   = 1;
            m_rd        = dec_rd;
            m_is_div    = dec_is_div;
            m_start_cyc = cyc + 1;
            m_ready_at  = cyc + 1 + lat_of(dec_is_div);
        end
    endtask

    // One cycle: compare mid-cycle, then advance the model at the edge.
    task automatic step();
        bit e_stall;
        bit e_wbreq;
        @(negedge clock);
        e_stall = model_stall();
        e_wbreq = m_pending && (cyc >= m_ready_at);
        check("stall", {31'd0, stall}, {31'd0, e_stall});
        check("busy", {31'd0, busy}, {31'd0, m_pending});
        check("wb_req", {31'd0, wb_req}, {31'd0, e_wbreq});
        if (e_wbreq) check("wb_rd", {27'd0, wb_rd}, {27'd0, m_rd});
        check("md_start", {31'd0, md_start}, {31'd0, (cyc == m_start_cyc)});
        if (cyc == m_start_cyc) check("md_is_div", {31'd0, md_is_div}, {31'd0, m_is_div});
        @(posedge clock);
        model_edge(e_stall);
        cyc++;
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        dec_valid  = 0;
        dec_is_md  = 0;
        dec_is_div = 0;
        dec_writes = 0;
        dec_rs     = '0;
        dec_rt     = '0;
        dec_rd     = '0;
        flush      = 0;
        wb_ack     = 0;
    endtask

    task automatic drive_md(input bit is_div, input logic [4:0] rd);
        drive_idle();
        dec_valid  = 1;
        dec_is_md  = 1;
        dec_is_div = is_div;
        dec_writes = 1;
        dec_rs     = 5'd1;
        dec_rt     = 5'd2;
        dec_rd     = rd;
    endtask

    task automatic drive_alu(input logic [4:0] rs, input logic [4:0] rt,
                             input bit writes, input logic [4:0] rd);
        drive_idle();
        dec_valid  = 1;
        dec_writes = writes;
        dec_rs     = rs;
        dec_rt     = rt;
        dec_rd     = rd;
    endtask

    // Step until wb_req is up, bounded; returns cycles waited.
    task automatic wait_wb(output int n);
        n = 0;
        while (wb_req !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        check("wb_wait", {31'd0, wb_req}, 32'd1);
    endtask

    function automatic logic [4:0] pick_reg();
        case ($urandom_range(0, 3))
            0: return 5'd0;
            1: return 5'd8;
            2: return m_rd;
            default: return 5'($urandom_range(0, 31));
        endcase
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int n;
        drive_idle();
        reset = 1;
        @(posedge clock);
        model_edge(0);
        cyc++;
        #1;
        step();
        check("rst_md_is_div", {31'd0, md_is_div}, 32'd0);
        check("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
        reset = 0;
        step();

        // Multiply to r8: start pulse, latency, writeback, release.
        drive_md(0, 5'd8);
        step();
        drive_idle();
        check("mul_start", {31'd0, md_start}, 32'd1);
        wait_wb(n);
        check("mul_lat", n, MUL_LAT);
        check("mul_wb_rd", {27'd0, wb_rd}, 32'd8);
        wb_ack = 1;
        step();
        wb_ack = 0;
        check("mul_release", {31'd0, busy}, 32'd0);
        step();

        // Divide to r8, then RAW / WAW / structural probes during BUSY.
        drive_md(1, 5'd8);
        step();
        drive_alu(5'd8, 5'd3, 0, 5'd4);  step();   // RAW on rs
        drive_alu(5'd9, 5'd0, 1, 5'd4);  step();   // no hit
        drive_alu(5'd1, 5'd8, 0, 5'd4);  step();   // RAW on rt
        drive_alu(5'd1, 5'd2, 1, 5'd8);  step();   // WAW
        drive_alu(5'd1, 5'd2, 0, 5'd8);  step();   // rd match but no write
        drive_md(1, 5'd5);               step();   // structural
        check("struct_no_start", {31'd0, md_start}, 32'd0);
        drive_idle();
        wait_wb(n);
        // Writeback held off for 10 cycles with a dependent reader waiting.
        drive_alu(5'd8, 5'd0, 0, 5'd0);
        for (int i = 0; i < 10; i++) step();
        check("hold_wb_req", {31'd0, wb_req}, 32'd1);
        check("hold_stall", {31'd0, stall}, 32'd1);
        wb_ack = 1;
        step();
        wb_ack = 0;
        check("reader_go", {31'd0, stall}, 32'd0);
        step();

        // Pending destination r0: nothing hazards, writeback still requested.
        drive_md(0, 5'd0);
        step();
        drive_alu(5'd0, 5'd0, 1, 5'd0);
        step();
        drive_idle();
        wait_wb(n);
        check("rd0_wb_rd", {27'd0, wb_rd}, 32'd0);
        wb_ack = 1;
        step();

        // Flush in IDLE: no accept.
        drive_md(0, 5'd7);
        flush = 1;
        step();
        drive_idle();
        step();
        check("flush_busy", {31'd0, busy}, 32'd0);

        // Reset mid-divide, then a fresh multiply right after.
        drive_md(1, 5'd12);
        step();
        drive_idle();
        for (int i = 0; i < 9; i++) step();
        reset = 1;
        step();
        reset = 0;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        drive_md(0, 5'd13);
        step();
        drive_idle();
        check("post_rst_start", {31'd0, md_start}, 32'd1);
        step();

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            reset      = ($urandom_range(0, 199) == 0);
            dec_valid  = ($urandom_range(0, 99) < 70);
            dec_is_md  = ($urandom_range(0, 99) < 25);
            dec_is_div = ($urandom_range(0, 99) < 20);
            dec_writes = $urandom_range(0, 1) == 1;
            dec_rs     = pick_reg();
            dec_rt     = pick_reg();
            dec_rd     = pick_reg();
            flush      = ($urandom_range(0, 99) < 10);
            wb_ack     = ($urandom_range(0, 99) < 35);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
